// File: rtl/hp_pkg.sv
// hp_pkg: shared classes, exception indices, canonical constants and FSM states for the hp float units
package hp_pkg;
  localparam int NTYPES      = 6;
  localparam int NEXCEPTIONS = 3;
  localparam int QNAN      = 0;
  localparam int SNAN      = 1;
  localparam int INFINITY  = 2;
  localparam int ZERO      = 3;
  localparam int SUBNORMAL = 4;
  localparam int NORMAL    = 5;
  localparam int INVALID   = 0;
  localparam int INEXACT   = 1;
  localparam int UNDERFLOW = 2;
  localparam logic [15:0] BF16_NAN  = 16'h7FC0;
  localparam logic [15:0] BF16_INF  = 16'h7F80;
  localparam logic [15:0] BF16_ZERO = 16'h0000;
  typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/hp_class.sv
// hp_class: one-hot class of an hp magnitude (sign excluded)
//   x    in   NEXP+NSIG   {exp, frac}
//   cls  out  NTYPES      one-hot QNAN/SNAN/INFINITY/ZERO/SUBNORMAL/NORMAL
module hp_class import hp_pkg::*; #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic [NEXP+NSIG-1:0] x,
  output logic [NTYPES-1:0]    cls
);
  logic [NEXP-1:0] ex;
  logic [NSIG-1:0] fr;
  logic emax, ez, fz;
  always_comb begin
    ex = x[NEXP+NSIG-1:NSIG];
    fr = x[NSIG-1:0];
    emax = &ex;
    ez = ~|ex;
    fz = ~|fr;
    cls = '0;
    cls[QNAN] = emax & fr[NSIG-1];
    cls[SNAN] = emax & ~fz & ~fr[NSIG-1];
    cls[INFINITY] = emax & fz;
    cls[ZERO] = ez & fz;
    cls[SUBNORMAL] = ez & ~fz;
    cls[NORMAL] = ~emax & ~ez;
  end
endmodule

// File: rtl/hp_sub.sv
// hp_sub: multi-cycle effective subtraction s = a + b with sign(b) taken as ~sign(a), RNE
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (ready only when idle)
//   a, b                 operands, W bits each
//   out_valid/out_ready  result handshake, result held until accepted
//   s                    result word
//   bfFlags              one-hot result class
//   exception            INVALID / INEXACT / UNDERFLOW for the last op
module hp_sub import hp_pkg::*; #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NEXP+NSIG:0]     a,
  input  logic [NEXP+NSIG:0]     b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NEXP+NSIG:0]     s,
  output logic [NTYPES-1:0]      bfFlags,
  output logic [NEXCEPTIONS-1:0] exception
);
  localparam int W = NEXP+NSIG+1;
  localparam int M = NSIG+4;
  localparam int SW = NSIG+2;
  localparam logic [W-1:0] CNAN = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
  state_t st;
  logic [NTYPES-1:0] ca, cb, sp_f;
  logic [W-1:0] ra, beff, sp_s;
  logic [W-2:0] rb;
  logic sgn, nan, invalid, special, swap, up, inexact, sub, sign_b_unused;
  logic [NEXP-1:0] e, efa, efb, ea, eb, d, re;
  logic [M-1:0] m, sm, ma, mb, msm, msh, diff, nm;
  logic [SW-1:0] sum;
  logic [NSIG:0] rsig;
  assign sign_b_unused = b[W-1];
  assign in_ready = st == IDLE;
  hp_class #(.NEXP(NEXP), .NSIG(NSIG)) u_ca (.x(a[W-2:0]), .cls(ca));
  hp_class #(.NEXP(NEXP), .NSIG(NSIG)) u_cb (.x(b[W-2:0]), .cls(cb));
  function automatic logic need(input logic [M-1:0] x, input logic [NEXP-1:0] ex);
    return !x[M-1] && ex > NEXP'(1);
  endfunction
  always_comb begin
    beff = {~a[W-1], b[W-2:0]};
    nan = ca[QNAN] | ca[SNAN] | cb[QNAN] | cb[SNAN] | (ca[INFINITY] & cb[INFINITY]);
    invalid = ca[SNAN] | cb[SNAN] | (ca[INFINITY] & cb[INFINITY]);
    special = nan | ca[INFINITY] | cb[INFINITY] | ca[ZERO] | cb[ZERO];
    sp_s = nan ? CNAN : ca[INFINITY] ? a : cb[INFINITY] ? beff :
           (ca[ZERO] & cb[ZERO]) ? '0 : ca[ZERO] ? beff : a;
    sp_f = nan ? (NTYPES'(1) << QNAN) : (ca[INFINITY] | cb[INFINITY]) ? (NTYPES'(1) << INFINITY) :
           ca[ZERO] ? cb : ca;
    efa = ra[W-2:NSIG];
    efb = rb[W-2:NSIG];
    ea = efa == '0 ? NEXP'(1) : efa;
    eb = efb == '0 ? NEXP'(1) : efb;
    ma = {|efa, ra[NSIG-1:0], 3'b000};
    mb = {|efb, rb[NSIG-1:0], 3'b000};
    swap = rb > ra[W-2:0];
    msm = swap ? ma : mb;
    d = swap ? eb - ea : ea - eb;
    // bits pushed past the S position are ORed into S
    msh = d >= NEXP'(M-1) ? M'(|msm) : (msm >> d) | M'(|(msm & ~({M{1'b1}} << d)));
    diff = m - sm;
    nm = {m[M-2:0], m[0]};
    up = m[2] & (m[1] | m[0] | m[3]);
    sum = {1'b0, m[M-1:3]} + SW'(up);
    rsig = sum[SW-1] ? sum[SW-1:1] : sum[NSIG:0];
    re = e + NEXP'(sum[SW-1]);
    inexact = |m[2:0];
    sub = !rsig[NSIG];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      out_valid <= 1'b0;
      s <= '0;
      bfFlags <= '0;
      exception <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          ra <= a;
          rb <= b[W-2:0];
          if (special) begin
            s <= sp_s;
            bfFlags <= sp_f;
            exception <= NEXCEPTIONS'(invalid) << INVALID;
            out_valid <= 1'b1;
            st <= DONE;
          end else st <= ALIGN;
        end
        ALIGN: begin
          sgn <= swap ? ~ra[W-1] : ra[W-1];
          e <= swap ? eb : ea;
          m <= swap ? mb : ma;
          sm <= msh;
          st <= SUB;
        end
        SUB: begin
          m <= diff;
          if (diff == '0) begin
            s <= '0;
            bfFlags <= NTYPES'(1) << ZERO;
            exception <= '0;
            out_valid <= 1'b1;
            st <= DONE;
          end else st <= need(diff, e) ? NORM : ROUND;
        end
        NORM: begin
          m <= nm;
          e <= e - NEXP'(1);
          st <= need(nm, e - NEXP'(1)) ? NORM : ROUND;
        end
        ROUND: begin
          s <= {sgn, sub ? NEXP'(0) : re, rsig[NSIG-1:0]};
          bfFlags <= sub ? (NTYPES'(1) << SUBNORMAL) : (NTYPES'(1) << NORMAL);
          exception <= (NEXCEPTIONS'(inexact) << INEXACT) | (NEXCEPTIONS'(inexact & sub) << UNDERFLOW);
          out_valid <= 1'b1;
          st <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hp_sub.sv
// tb_hp_sub: randomized self-checking bench for hp_sub against an arithmetic reference model
module tb_hp_sub;
  import hp_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [15:0] a = 0, b = 0;
  logic in_ready, out_valid;
  logic [15:0] s;
  logic [5:0] bfFlags;
  logic [2:0] exception;
  int checks = 0, errors = 0;
  int cyc = 0, acc = 0, acc_n = 0, hand_n = 0, seen_n = 0;
  logic [15:0] xs;
  logic [5:0] xf;
  logic [2:0] xx;
  int xlat;
  bit bp = 0, hold = 0;
  logic [15:0] sp [8] = '{16'h7F80, 16'hFF80, 16'h7FC0, 16'h7F81, 16'h0000, 16'h8000, 16'h0001, 16'h0080};

  hp_sub dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
              .out_valid(out_valid), .out_ready(out_ready), .s(s), .bfFlags(bfFlags), .exception(exception));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] oh(input int i);
    return 6'(1) << i;
  endfunction

  function automatic void model(input logic [15:0] x, y, output logic [15:0] rs,
                                output logic [5:0] rf, output logic [2:0] rx, output int lat);
    int ex = int'(x[14:7]), ey = int'(y[14:7]), fx = int'(x[6:0]), fy = int'(y[6:0]);
    bit nx = ex == 255 && fx != 0, ny = ey == 255 && fy != 0;
    bit snx = nx && fx < 64, sny = ny && fy < 64;
    bit ix = ex == 255 && fx == 0, iy = ey == 255 && fy == 0;
    bit zx = ex == 0 && fx == 0, zy = ey == 0 && fy == 0;
    logic sx = x[15], sy = ~x[15], sg;
    int el, es, sl, ss, d, ml, ms, diff, k, e, q, rem;
    rx = 0;
    lat = 1;
    if (nx || ny || (ix && iy)) begin
      rs = 16'h7FC0; rf = oh(QNAN);
      rx = (snx || sny || (ix && iy)) ? 3'(1) << INVALID : 3'b0;
    end else if (ix) begin rs = x; rf = oh(INFINITY); end
    else if (iy) begin rs = {sy, y[14:0]}; rf = oh(INFINITY); end
    else if (zx && zy) begin rs = 16'h0000; rf = oh(ZERO); end
    else if (zx) begin rs = {sy, y[14:0]}; rf = ey == 0 ? oh(SUBNORMAL) : oh(NORMAL); end
    else if (zy) begin rs = x; rf = ex == 0 ? oh(SUBNORMAL) : oh(NORMAL); end
    else begin
      if (x[14:0] >= y[14:0]) begin el = ex; sl = fx; es = ey; ss = fy; sg = sx; end
      else begin el = ey; sl = fy; es = ex; ss = fx; sg = sy; end
      if (el != 0) sl += 128; else el = 1;
      if (es != 0) ss += 128; else es = 1;
      d = el - es;
      ml = sl * 8;
      if (d >= 10) ms = 1;
      else ms = ((ss * 8) >> d) | ((((ss * 8) % (1 << d)) != 0) ? 1 : 0);
      diff = ml - ms;
      if (diff == 0) begin rs = 16'h0000; rf = oh(ZERO); lat = 3; end
      else begin
        k = 0; e = el;
        while (diff < 1024 && e > 1) begin diff = diff * 2 + diff % 2; e--; k++; end
        q = diff / 8; rem = diff % 8;
        if (rem > 4 || (rem == 4 && q % 2 == 1)) q++;
        if (q == 256) begin q = 128; e++; end
        if (q < 128) e = 0;
        rs = {sg, 8'(e), 7'(q % 128)};
        rf = e == 0 ? oh(SUBNORMAL) : oh(NORMAL);
        rx = (3'(rem != 0) << INEXACT) | (3'(rem != 0 && e == 0) << UNDERFLOW);
        lat = 4 + k;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on the DUT", name);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic pin(input logic [15:0] x, y, input logic [15:0] es, input logic [5:0] ef,
                     input logic [2:0] ex, input int el);
    logic [15:0] ms; logic [5:0] mf; logic [2:0] mx; int ml;
    model(x, y, ms, mf, mx, ml);
    chk($sformatf("model s %h+%h", x, y), ms, es);
    chk($sformatf("model class %h+%h", x, y), mf, ef);
    chk($sformatf("model exc %h+%h", x, y), mx, ex);
    chk($sformatf("model latency %h+%h", x, y), ml, el);
  endtask

  task automatic start_op(input logic [15:0] x, y);
    int t = 0;
    while (!in_ready) begin
      if (t >= 60) bail("in_ready");
      @(negedge clk); t++;
    end
    model(x, y, xs, xf, xx, xlat);
    acc = cyc + 1;
    acc_n++;
    in_valid = 1; a = x; b = y;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (hand_n != acc_n) begin
      if (t >= 60) bail("result handoff");
      @(negedge clk); t++;
    end
  endtask

  always @(negedge clk) if (!rst && out_valid) begin
    if (acc_n == hand_n) begin
      checks++; errors++;
      $display("FAIL spurious out_valid: got 1 expected 0 (t=%0t)", $time);
    end else begin
      if (seen_n != acc_n) begin
        chk("latency", cyc - acc + 1, xlat);
        seen_n = acc_n;
      end
      chk("s", s, xs);
      chk("bfFlags", bfFlags, xf);
      chk("exception", exception, xx);
      chk("in_ready while done", in_ready, 0);
    end
  end

  always @(posedge clk) if (!rst && out_valid && out_ready && acc_n != hand_n) hand_n <= hand_n + 1;

  initial forever begin
    @(negedge clk);
    out_ready = hold ? 1'b0 : bp ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial begin
    int t, e2;
    logic [15:0] x, y;
    pin(16'h3F80, 16'hBF00, 16'h3F00, oh(NORMAL), 3'b000, 5);
    pin(16'h4040, 16'hC040, 16'h0000, oh(ZERO), 3'b000, 3);
    pin(16'h7F80, 16'hFF80, BF16_NAN, oh(QNAN), 3'b001, 1);
    pin(16'h7F81, 16'h3F80, BF16_NAN, oh(QNAN), 3'b001, 1);
    pin(16'h0081, 16'h8080, 16'h0001, oh(SUBNORMAL), 3'b000, 4);
    pin(16'h3F80, 16'hB380, 16'h3F80, oh(NORMAL), 3'b010, 5);
    repeat (3) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset s", s, 0);
    chk("reset bfFlags", bfFlags, 0);
    chk("reset exception", exception, 0);
    rst = 0;
    @(negedge clk);
    start_op(16'h3F80, 16'hBF00); wait_done();
    start_op(16'h4040, 16'hC040); wait_done();
    start_op(16'h7F80, 16'hFF80); wait_done();
    start_op(16'h7F81, 16'h3F80); wait_done();
    start_op(16'h0081, 16'h8080); wait_done();
    start_op(16'h3F80, 16'hB380); wait_done();
    hold = 1;
    start_op(16'h3F80, 16'hBF00);
    t = 0;
    while (!out_valid) begin
      if (t >= 60) bail("out_valid under backpressure");
      @(negedge clk); t++;
    end
    repeat (5) begin
      in_valid = 1; a = 16'h4040; b = 16'hC000;
      @(negedge clk);
    end
    chk("held out_valid", out_valid, 1);
    in_valid = 0;
    hold = 0;
    wait_done();
    in_valid = 1; a = 16'h3F80; b = 16'hBF00;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mid-op reset out_valid", out_valid, 0);
    chk("mid-op reset in_ready", in_ready, 1);
    chk("mid-op reset s", s, 0);
    rst = 0;
    @(negedge clk);
    bp = 1;
    for (int i = 0; i < 400; i++) begin
      x = 16'($urandom);
      case ($urandom_range(0, 3))
        0: y = 16'($urandom);
        1: begin
          e2 = int'(x[14:7]) + int'($urandom_range(0, 4)) - 2;
          e2 = e2 < 0 ? 0 : e2 > 254 ? 254 : e2;
          y = {1'($urandom), 8'(e2), 7'($urandom)};
        end
        2: y = {1'($urandom), x[14:7], 7'($urandom)};
        default: begin
          y = sp[$urandom_range(0, 7)];
          if ($urandom_range(0, 1) == 1) begin x = y; y = 16'($urandom); end
        end
      endcase
      start_op(x, y);
      wait_done();
    end
    bp = 0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
